clkdiv_multi: RTL

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/clkdiv_channel.sv | 94 +++++++++
 rtl/clkdiv_multi.sv | 65 ++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// The optional phase-alignment input is enabled with `define CLKDIV_SYNC_EN.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W       = 32;
  localparam int CLKDIV_DEFAULT_DIV = 70000000;
  localparam int CLKDIV_MAX_CH      = 16;

  typedef logic [CLKDIV_CNT_W-1:0] div_t;

  // What a channel does on the coming CLOCK edge
  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_COUNT,
    MODE_TERM,
    MODE_SYNC
  } ch_mode_e;

  function automatic int clkdiv_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: active divisor, one-deep pending divisor, counter and outputs.
// With `define CLKDIV_SYNC_EN a sync_in input phase-aligns the channel.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int   CNT_W       = CLKDIV_CNT_W,
  parameter div_t DEFAULT_DIV = div_t'(CLKDIV_DEFAULT_DIV)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic             sync_hit;
  ch_mode_e         mode;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  // Sync outranks a terminal count landing on the same edge
  always_comb begin
    mode = MODE_IDLE;
    if (sync_hit) begin
      mode = MODE_SYNC;
    end else if (en && (div != '0)) begin
      mode = (cnt == (div - CNT_W'(1))) ? MODE_TERM : MODE_COUNT;
    end
  end

  // A pending divisor only replaces the active one where cnt restarts at 0,
  // so a running clk_out never sees a shortened phase.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt      <= '0;
      div      <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (mode)
        MODE_SYNC: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (pending) begin
            div     <= pend_div;
            pending <= 1'b0;
          end
        end
        MODE_TERM: begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          if (pending) begin
            div     <= pend_div;
            pending <= 1'b0;
          end
        end
        MODE_COUNT: begin
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
          if (pending) begin
            div     <= pend_div;
            pending <= 1'b0;
            cnt     <= '0;
          end
        end
      endcase
      // Writes are only accepted while nothing is pending, so this never
      // collides with the apply paths above.
      if (wr) begin
        pending  <= 1'b1;
        pend_div <= wr_div;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: divisor write decode plus NUM_CH independent channels.
// With `define CLKDIV_SYNC_EN the extra sync_in input phase-aligns every channel.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   CNT_W       = CLKDIV_CNT_W,
  parameter div_t DEFAULT_DIV = div_t'(CLKDIV_DEFAULT_DIV)
) (
  input  logic                             CLOCK,
  input  logic                             RESET_N,
  input  logic [NUM_CH-1:0]                en,
`ifdef CLKDIV_SYNC_EN
  input  logic                             sync_in,
`endif
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [clkdiv_ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]                 cfg_div,
  output logic [NUM_CH-1:0]                clk_out,
  output logic [NUM_CH-1:0]                tick
);

  localparam int CH_W = clkdiv_ch_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;

  // Out-of-range channel numbers match nothing, so they are accepted and dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((cfg_ch == CH_W'(i)) && pending[i]) begin
        cfg_ready = 1'b0;
      end
    end
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .en      (en[g]),
`ifdef CLKDIV_SYNC_EN
      .sync_in (sync_in),
`endif
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule
